lsu_mem_ctrl: RTL and testbench

Load/store initiator between the single-cycle core's execute stage and the word-organised data memory.
- Accepts one load or store request per handshake.
- Drives the memory's word-only read/write port; the memory read is combinational and the write commits on posedge.
- Performs byte/halfword lane extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Flags misaligned, out-of-range and illegal-funct3 accesses as errors without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core execute stage and a word-organised data memory.
// Performs lane extraction with extension for loads and read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
    parameter int XLEN       = 32,
    parameter int MEM_ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [2:0]      state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the response holds valid, data and err stable until resp_ready is seen.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0] addr_q;
    logic [2:0]      funct3_q;
    logic            we_q;
    logic            err_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] merge_q;

    logic            accept;
    logic            f3_bad;
    logic            misaligned;
    logic            out_of_range;
    logic            req_err;
    logic [7:0]      byte_val;
    logic [15:0]     half_val;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merge_data;

    assign accept    = req_valid && req_ready;
    assign state_dbg = state;
    assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};

    // Request checks are evaluated on the live request so faults skip memory entirely.
    always_comb begin
        f3_bad = 1'b0;
        if (req_we) begin
            f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = (req_addr >> MEM_ADDR_W) != '0;
    assign req_err      = f3_bad || misaligned || out_of_range;

    // Load lane selection and extension.
    always_comb begin
        byte_val = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_val = mem_rdata[7:0];
            2'd1:    byte_val = mem_rdata[15:8];
            2'd2:    byte_val = mem_rdata[23:16];
            default: byte_val = mem_rdata[31:24];
        endcase
    end

    assign half_val = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){byte_val[7]}}, byte_val};
            3'b001:  load_data = {{(XLEN-16){half_val[15]}}, half_val};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_val};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_val};
            default: load_data = mem_rdata;
        endcase
    end

    // merge_q carries the store data until the old word arrives, then the merged word.
    always_comb begin
        merge_data = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merge_data[7:0]   = merge_q[7:0];
                2'd1:    merge_data[15:8]  = merge_q[7:0];
                2'd2:    merge_data[23:16] = merge_q[7:0];
                default: merge_data[31:24] = merge_q[7:0];
            endcase
        end else begin
            if (addr_q[1]) begin
                merge_data[31:16] = merge_q[15:0];
            end else begin
                merge_data[15:0] = merge_q[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = S_RESP;
                    end else if (!req_we) begin
                        state_next = S_RD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_next = S_WR;
                    end else begin
                        state_next = S_RMW_RD;
                    end
                end
            end
            S_RD:     state_next = S_RESP;
            S_RMW_RD: state_next = S_WR;
            S_WR:     state_next = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        case (state)
            S_IDLE:   req_ready = rst;
            S_RD:     mem_read  = 1'b1;
            S_RMW_RD: mem_read  = 1'b1;
            S_WR: begin
                mem_write = 1'b1;
                mem_wdata = merge_q;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = (we_q || err_q) ? '0 : rdata_q;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            merge_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        err_q    <= req_err;
                        rdata_q  <= '0;
                        merge_q  <= req_wdata;
                    end
                end
                S_RD:     rdata_q <= load_data;
                S_RMW_RD: merge_q <= merge_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural word memory and
// immediate-assertion checks against hand-computed values.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  logic        preload;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = '0;
  int          rd_base;
  int          wr_base;
  int          lat;

  lsu_mem_ctrl #(.XLEN(32), .MEM_ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, posedge write
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8001_7F11;
      mem[1] <= 32'h1122_3344;
    end else begin
      if (mem_write) begin
        mem[mem_addr[7:2]] <= mem_wdata;
        last_wdata <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (mem_read) rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and measure cycles from the acceptance edge to resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int l);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    l = 1;
    while (!resp_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input int l, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_err);
    chk({tag, "_lat"}, l, exp_lat);
    chk({tag, "_rdata"}, resp_rdata, exp_data);
    chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
  endtask

  initial begin
    rst        = 1'b0;
    preload    = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;

    // reset state
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_state", {29'b0, state_dbg}, 32'd0);

    rst = 1'b1;
    @(posedge clk); #1;

    // full word load
    do_req(1'b0, 3'b010, 32'h0, 32'h0, lat);
    chk_resp("lw0", lat, 2, 32'h8001_7F11, 1'b0);
    finish_resp();

    // sub-word loads
    do_req(1'b0, 3'b000, 32'h3, 32'h0, lat);
    chk_resp("lb3", lat, 2, 32'hFFFF_FF80, 1'b0);
    finish_resp();
    do_req(1'b0, 3'b100, 32'h3, 32'h0, lat);
    chk_resp("lbu3", lat, 2, 32'h0000_0080, 1'b0);
    finish_resp();
    do_req(1'b0, 3'b001, 32'h2, 32'h0, lat);
    chk_resp("lh2", lat, 2, 32'hFFFF_8001, 1'b0);
    finish_resp();
    do_req(1'b0, 3'b101, 32'h0, 32'h0, lat);
    chk_resp("lhu0", lat, 2, 32'h0000_7F11, 1'b0);
    finish_resp();

    // sub-word stores via read-modify-write
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    do_req(1'b1, 3'b000, 32'h5, 32'h0000_00AB, lat);
    chk_resp("sb5", lat, 3, 32'h0, 1'b0);
    chk("sb5_reads", rd_cnt - rd_base, 32'd1);
    chk("sb5_writes", wr_cnt - wr_base, 32'd1);
    chk("sb5_wdata", last_wdata, 32'h1122_AB44);
    chk("sb5_mem", mem[1], 32'h1122_AB44);
    finish_resp();

    do_req(1'b1, 3'b001, 32'h6, 32'h0000_BEEF, lat);
    chk_resp("sh6", lat, 3, 32'h0, 1'b0);
    chk("sh6_mem", mem[1], 32'hBEEF_AB44);
    finish_resp();

    // faulting requests
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    do_req(1'b0, 3'b001, 32'h1, 32'h0, lat);
    chk_resp("lh1_misal", lat, 1, 32'h0, 1'b1);
    finish_resp();
    do_req(1'b1, 3'b010, 32'h6, 32'hDEAD_BEEF, lat);
    chk_resp("sw6_misal", lat, 1, 32'h0, 1'b1);
    finish_resp();
    do_req(1'b0, 3'b011, 32'h0, 32'h0, lat);
    chk_resp("ld_f3_011", lat, 1, 32'h0, 1'b1);
    finish_resp();
    do_req(1'b0, 3'b010, 32'h100, 32'h0, lat);
    chk_resp("lw_range", lat, 1, 32'h0, 1'b1);
    finish_resp();
    chk("err_reads", rd_cnt - rd_base, 32'd0);
    chk("err_writes", wr_cnt - wr_base, 32'd0);
    chk("err_mem1", mem[1], 32'hBEEF_AB44);

    // response back-pressure
    do_req(1'b0, 3'b010, 32'h4, 32'h0, lat);
    chk_resp("lw4_hold", lat, 2, 32'hBEEF_AB44, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, 32'hBEEF_AB44);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    finish_resp();
    chk("post_resp_ready", {31'b0, req_ready}, 32'd1);
    chk("post_resp_state", {29'b0, state_dbg}, 32'd0);

    // reset during the write phase of a byte store
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h4;
    req_wdata  = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_state", {29'b0, state_dbg}, 32'd2);
    @(posedge clk); #1;
    chk("wr_state", {29'b0, state_dbg}, 32'd3);
    chk("wr_mem_write", {31'b0, mem_write}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("arst_state", {29'b0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    chk("arst_mem1", mem[1], 32'hBEEF_AB44);
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 3'b010, 32'h4, 32'h0, lat);
    chk_resp("lw4_after_rst", lat, 2, 32'hBEEF_AB44, 1'b0);
    finish_resp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
